// File: rtl/i2c_target.sv
// I2C target engine: filters raw SCL/SDA, detects START/STOP, matches a 7-bit address,
// and moves bytes between the bus and the fabric. SDA is driven open-drain via sda_oe_o.
module i2c_target #(
    parameter logic [6:0]  ADDRESS    = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       rw_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_last_q, scl_last_d, sda_last_q, sda_last_d;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;

    logic       scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] byte_in;

    // Synchroniser and counter filter: the filtered level flips after FLEN disagreeing samples
    always_comb begin
        scl_s1_d   = scl_i;
        scl_s2_d   = scl_s1_q;
        sda_s1_d   = sda_i;
        sda_s2_d   = sda_s1_q;
        scl_last_d = scl_f_q;
        sda_last_d = sda_f_q;
        scl_f_d    = scl_f_q;
        scl_cnt_d  = '0;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == FLEN - 4'd1) scl_f_d = scl_s2_q;
            else scl_cnt_d = scl_cnt_q + 4'd1;
        end
        sda_f_d    = sda_f_q;
        sda_cnt_d  = '0;
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == FLEN - 4'd1) sda_f_d = sda_s2_q;
            else sda_cnt_d = sda_cnt_q + 4'd1;
        end
    end

    assign scl_rise  = scl_f_q & ~scl_last_q;
    assign scl_fall  = ~scl_f_q & scl_last_q;
    assign start_evt = scl_f_q & ~sda_f_q & sda_last_q;
    assign stop_evt  = scl_f_q & sda_f_q & ~sda_last_q;
    assign byte_in   = {shift_q[6:0], sda_f_q};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        if (start_evt) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            start_d   = 1'b1;
        end else if (stop_evt) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_in[7:1] == ADDRESS && byte_in[7:1] != 7'h00) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                // sda_oe_q doubles as the phase flag: clear before the ACK bit, set during it
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        shift_d   = tx_data_i;
                        sda_oe_d  = ~tx_data_i[7];
                        bit_cnt_d = '0;
                        state_d   = ST_READ;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WRITE;
                    end
                end else if (scl_rise && sda_oe_q) begin
                    busy_d   = 1'b1;
                    tx_req_d = rw_q;
                end
                ST_WRITE: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WRITE;
                    end
                end
                ST_READ: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_READ_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], shift_q[7]};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // bit_cnt_q marks an ACK already seen, so the next fall reloads the shifter
                ST_READ_ACK: begin
                    if (scl_rise && bit_cnt_q == 3'd0) begin
                        if (!sda_f_q) begin
                            tx_req_d  = 1'b1;
                            bit_cnt_d = 3'd1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt_q == 3'd1) begin
                        shift_d   = tx_data_i;
                        sda_oe_d  = ~tx_data_i[7];
                        bit_cnt_d = '0;
                        state_d   = ST_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_last_q <= 1'b1;
            sda_last_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_last_q <= scl_last_d;
            sda_last_q <= sda_last_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;
    assign rw_o       = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller drives a wired-AND bus,
// written/read bytes are matched against scoreboard queues.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe_o, rx_valid_o, tx_req_o, start_o, stop_o, busy_o, rw_o;
    logic [7:0] rx_data_o;

    assign sda_bus = sda_m & ~sda_oe_o;

    i2c_target #(.ADDRESS(7'h50), .FILTER_LEN(3)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe_o  (sda_oe_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .tx_data_i (tx_data),
        .tx_req_o  (tx_req_o),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .busy_o    (busy_o),
        .rw_o      (rw_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_stop = 0, n_tx = 0, n_rx = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0;
    logic [7:0] rx_exp[$];
    logic [7:0] rd_exp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_o) n_start++;
        if (stop_o) n_stop++;
        if (tx_req_o) n_tx++;
        if (sda_oe_o) oe_seen = 1'b1;
        if (busy_o) busy_seen = 1'b1;
        if (rx_valid_o) begin
            n_rx++;
            check("rx_pending", 32'(rx_exp.size() != 0), 32'd1);
            if (rx_exp.size() != 0) check("rx_data", 32'(rx_data_o), 32'(rx_exp.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tick(Q); sda_m = b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        tick(Q); sda_m = 1'b1; tick(Q);
        acked = sda_oe_o & ~sda_bus;
        scl = 1'b1; tick(2*Q); scl = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            tick(Q); sda_m = 1'b1; tick(Q);
            b = {b[6:0], sda_bus};
            scl = 1'b1; tick(2*Q); scl = 1'b0;
        end
    endtask

    task automatic start_cond();
        tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(2*Q);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] addr_w;
        int s0, p0, t0, r0;

        tick(3);
        check("rst_oe", 32'(sda_oe_o), 32'd0);
        check("rst_rx_data", 32'(rx_data_o), 32'h00);
        check("rst_pulses", 32'({rx_valid_o, tx_req_o, start_o, stop_o}), 32'd0);
        check("rst_busy_rw", 32'({busy_o, rw_o}), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Write 0x3C, 0xC3 to 0x50
        s0 = n_start; p0 = n_stop; r0 = n_rx;
        start_cond();
        send_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        check("wr_busy", 32'(busy_o), 32'd1);
        check("wr_rw", 32'(rw_o), 32'd0);
        rx_exp.push_back(8'h3C);
        send_byte(8'h3C, ack);
        check("wr_d0_ack", 32'(ack), 32'd1);
        rx_exp.push_back(8'hC3);
        send_byte(8'hC3, ack);
        check("wr_d1_ack", 32'(ack), 32'd1);
        check("wr_busy_end", 32'(busy_o), 32'd1);
        stop_cond();
        check("wr_busy_after_stop", 32'(busy_o), 32'd0);
        check("wr_start_cnt", 32'(n_start - s0), 32'd1);
        check("wr_stop_cnt", 32'(n_stop - p0), 32'd1);
        check("wr_rx_cnt", 32'(n_rx - r0), 32'd2);

        // Read 0x96 then 0x5A, ACK then NACK
        t0 = n_tx;
        tx_data = 8'h96; rd_exp.push_back(8'h96);
        start_cond();
        send_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        check("rd_rw", 32'(rw_o), 32'd1);
        read_byte(b);
        check("rd_byte0", 32'(b), 32'(rd_exp.pop_front()));
        tx_data = 8'h5A; rd_exp.push_back(8'h5A);
        send_bit(1'b0);
        read_byte(b);
        check("rd_byte1", 32'(b), 32'(rd_exp.pop_front()));
        send_bit(1'b1);
        tick(4);
        check("rd_nack_busy", 32'(busy_o), 32'd0);
        check("rd_nack_oe", 32'(sda_oe_o), 32'd0);
        check("rd_tx_cnt", 32'(n_tx - t0), 32'd2);
        stop_cond();

        // Non-matching addresses 0x51 and 0x00
        oe_seen = 1'b0; busy_seen = 1'b0; r0 = n_rx;
        for (int k = 0; k < 2; k++) begin
            addr_w = (k == 0) ? 8'hA2 : 8'h00;
            start_cond();
            send_byte(addr_w, ack);
            check("mm_addr_ack", 32'(ack), 32'd0);
            send_byte(8'h3C, ack);
            check("mm_data_ack", 32'(ack), 32'd0);
            stop_cond();
        end
        check("mm_oe_seen", 32'(oe_seen), 32'd0);
        check("mm_busy_seen", 32'(busy_seen), 32'd0);
        check("mm_rx_cnt", 32'(n_rx - r0), 32'd0);

        // Repeated START after 4 data bits, then read
        s0 = n_start; r0 = n_rx; t0 = n_tx;
        tx_data = 8'h77;
        start_cond();
        send_byte(8'hA0, ack);
        check("rs_wr_ack", 32'(ack), 32'd1);
        check("rs_rw0", 32'(rw_o), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        start_cond();
        rd_exp.push_back(8'h77);
        send_byte(8'hA1, ack);
        check("rs_rd_ack", 32'(ack), 32'd1);
        check("rs_rw1", 32'(rw_o), 32'd1);
        read_byte(b);
        check("rs_byte", 32'(b), 32'(rd_exp.pop_front()));
        send_bit(1'b1);
        stop_cond();
        check("rs_start_cnt", 32'(n_start - s0), 32'd2);
        check("rs_rx_cnt", 32'(n_rx - r0), 32'd0);
        check("rs_tx_cnt", 32'(n_tx - t0), 32'd1);

        // Glitch immunity with SCL high
        s0 = n_start; p0 = n_stop;
        sda_m = 1'b0; tick(2); sda_m = 1'b1; tick(30);
        check("gl_short_start", 32'(n_start - s0), 32'd0);
        sda_m = 1'b0; tick(4); sda_m = 1'b1; tick(30);
        check("gl_long_start", 32'(n_start - s0), 32'd1);
        check("gl_long_stop", 32'(n_stop - p0), 32'd1);

        // Asynchronous reset while ACKing the address
        start_cond();
        addr_w = 8'hA0;
        for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
        tick(Q);
        check("ar_oe_before", 32'(sda_oe_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("ar_oe_async", 32'(sda_oe_o), 32'd0);
        tick(3);
        check("ar_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        tick(Q); scl = 1'b1; tick(2*Q);
        r0 = n_rx;
        start_cond();
        send_byte(8'hA0, ack);
        check("ar_addr_ack", 32'(ack), 32'd1);
        rx_exp.push_back(8'h11);
        send_byte(8'h11, ack);
        check("ar_data_ack", 32'(ack), 32'd1);
        stop_cond();
        check("ar_rx_cnt", 32'(n_rx - r0), 32'd1);

        check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
